// File: rtl/prog_ram.sv
// Writable program memory: streaming loader fills words from address 0; fetch is request/valid, 1-cycle latency.
// Backpressure: load_ready only in LOAD, fetch_ready only in IDLE; both decoded from the state register.
module prog_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              fetch_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] adres,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] out,
  output logic              fetch_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   wptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  assign fetch_ready = (state == IDLE);
  assign load_ready  = (state == LOAD);
  assign in_range    = ({1'b0, adres} < DEPTH_L);

  // Storage has no reset: a reset mid-load must keep already written words.
  always_ff @(posedge clk) begin
    if (load_ready && load_valid) begin
      mem[wptr[IW-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      wptr        <= '0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      out         <= '0;
    end else begin
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;

      if (fetch_req && fetch_ready) begin
        fetch_valid <= 1'b1;
        fetch_err   <= !in_range;
        out         <= in_range ? mem[adres[IW-1:0]] : '0;
      end

      case (state)
        IDLE: begin
          if (load_start) begin
            if (load_len == '0) begin
              load_done <= 1'b1;
            end else begin
              // Clamp so words beyond the implemented depth are never accepted.
              len   <= (load_len > DEPTH_L) ? DEPTH_L : load_len;
              wptr  <= '0;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (load_valid) begin
            wptr <= wptr + 1'b1;
            if (wptr == len - 1'b1) begin
              state     <= IDLE;
              load_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
